// File: rtl/ram_zmem_dp_mask_if.sv
// Write/read port bundle for ram_zmem_dp_mask; master drives requests, slave is the memory.
interface ram_zmem_dp_mask_if #(
    parameter int WIDTH  = 9,
    parameter int AW     = 8,
    parameter int NLANES = 2
);
    logic [WIDTH-1:0]  w0di;
    logic [AW-1:0]     w0addr;
    logic              w0we;
    logic [NLANES-1:0] w0mask;
    logic [AW-1:0]     r0addr;
    logic              r0re;
    logic [WIDTH-1:0]  r0do;
    logic              r0vld;
    logic              init_busy;

    modport master (
        output w0di, w0addr, w0we, w0mask, r0addr, r0re,
        input  r0do, r0vld, init_busy
    );

    modport slave (
        input  w0di, w0addr, w0we, w0mask, r0addr, r0re,
        output r0do, r0vld, init_busy
    );
endinterface

// File: rtl/ram_zmem_dp_mask.sv
// 1W/1R memory with lane-masked writes, read-before-write collisions and a post-reset clear sweep.
// Read latency 1 cycle; no backpressure, requests are dropped while init_busy is high.
module ram_zmem_dp_mask #(
    parameter int WIDTH          = 9,
    parameter int DEPTH          = 256,
    parameter int WORD_LEN       = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             rst,
    ram_zmem_dp_mask_if.slave bus
);
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NLANES = (WIDTH + WORD_LEN - 1) / WORD_LEN;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    logic [WIDTH-1:0] mem_q [DEPTH];

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r0do_q, r0do_d;
    logic             r0vld_q, r0vld_d;

    logic             w_in_range, r_in_range;
    logic             clr_we, wr_en;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] wr_dat;

    assign w_in_range = ({1'b0, bus.w0addr} < DEPTH_W);
    assign r_in_range = ({1'b0, bus.r0addr} < DEPTH_W);

    // Lane enables fan out to bits; the top lane is naturally clipped at WIDTH.
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bit_mask[i] = bus.w0mask[i / WORD_LEN];
        end
        wr_dat = (mem_q[bus.w0addr] & ~bit_mask) | (bus.w0di & bit_mask);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r0do_d  = r0do_q;
        r0vld_d = 1'b0;
        clr_we  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                wr_en = bus.w0we && w_in_range;
                if (bus.r0re) begin
                    r0vld_d = 1'b1;
                    r0do_d  = r_in_range ? mem_q[bus.r0addr] : '0;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            r0do_q  <= '0;
            r0vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r0do_q  <= r0do_d;
            r0vld_q <= r0vld_d;
        end
    end

    // Storage has no reset; the sweep provides the zero state. Read data was captured above
    // from the pre-edge contents, which gives read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[bus.w0addr] <= wr_dat;
        end
    end

    assign bus.r0do      = r0do_q;
    assign bus.r0vld     = r0vld_q;
    assign bus.init_busy = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_ram_zmem_dp_mask.sv
// Randomized self-checking bench: a 256-deep and a 200-deep instance against array reference models.
module tb_ram_zmem_dp_mask;
    logic clk = 1'b0;
    logic rst_a, rst_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] ma [256];
    logic [8:0] mb [200];
    logic [8:0] last_do [2];

    ram_zmem_dp_mask_if #(.WIDTH(9), .AW(8), .NLANES(2)) a_if ();
    ram_zmem_dp_mask_if #(.WIDTH(9), .AW(8), .NLANES(2)) b_if ();

    ram_zmem_dp_mask #(.WIDTH(9), .DEPTH(256), .WORD_LEN(8), .CLEAR_ON_RESET(1)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if)
    );

    ram_zmem_dp_mask #(.WIDTH(9), .DEPTH(200), .WORD_LEN(8), .CLEAR_ON_RESET(1)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_if.w0we = 1'b0; a_if.r0re = 1'b0; a_if.w0mask = '0;
        a_if.w0di = '0;   a_if.w0addr = '0; a_if.r0addr = '0;
        b_if.w0we = 1'b0; b_if.r0re = 1'b0; b_if.w0mask = '0;
        b_if.w0di = '0;   b_if.w0addr = '0; b_if.r0addr = '0;
    endtask

    // One READY-state cycle on instance sel (0: depth 256, 1: depth 200).
    task automatic op(input int sel, input bit we, input int waddr, input logic [8:0] wd,
                      input logic [1:0] m, input bit re, input int raddr, input string tag);
        int         depth;
        logic [8:0] exp;
        logic [8:0] old;
        logic [8:0] nv;
        depth = (sel == 0) ? 256 : 200;
        exp = last_do[sel];
        if (re) begin
            if (raddr < depth) exp = (sel == 0) ? ma[raddr] : mb[raddr];
            else               exp = 9'h000;
        end
        if (sel == 0) begin
            a_if.w0we = we; a_if.w0addr = 8'(waddr); a_if.w0di = wd; a_if.w0mask = m;
            a_if.r0re = re; a_if.r0addr = 8'(raddr);
        end else begin
            b_if.w0we = we; b_if.w0addr = 8'(waddr); b_if.w0di = wd; b_if.w0mask = m;
            b_if.r0re = re; b_if.r0addr = 8'(raddr);
        end
        cyc();
        if (we && waddr < depth) begin
            old = (sel == 0) ? ma[waddr] : mb[waddr];
            nv  = old;
            for (int i = 0; i < 9; i++) if (m[i / 8]) nv[i] = wd[i];
            if (sel == 0) ma[waddr] = nv;
            else          mb[waddr] = nv;
        end
        idle();
        if (sel == 0) begin
            chk({tag, "_vld"}, 32'(a_if.r0vld), 32'(re));
            chk({tag, "_do"},  32'(a_if.r0do),  32'(exp));
        end else begin
            chk({tag, "_vld"}, 32'(b_if.r0vld), 32'(re));
            chk({tag, "_do"},  32'(b_if.r0do),  32'(exp));
        end
        last_do[sel] = exp;
    endtask

    // Counts busy cycles per instance after reset release; optionally pokes requests into A while busy.
    task automatic clear_count(input bit gate, output int na, output int nb);
        int n;
        n  = 0;
        na = 0;
        nb = 0;
        while ((a_if.init_busy || b_if.init_busy) && n < 2000) begin
            if (a_if.init_busy) na++;
            if (b_if.init_busy) nb++;
            if (gate && n < 10) begin
                a_if.w0we = 1'b1; a_if.w0addr = 8'd3; a_if.w0di = 9'h1FF; a_if.w0mask = 2'b11;
                a_if.r0re = 1'b1; a_if.r0addr = 8'd3;
            end else begin
                idle();
            end
            cyc();
            if (gate && n < 10) chk("busy_gate_vld", 32'(a_if.r0vld), 32'd0);
            n++;
        end
        idle();
        if (n >= 2000) chk("clear_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int na, nb;
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle();
        for (int i = 0; i < 256; i++) ma[i] = '0;
        for (int i = 0; i < 200; i++) mb[i] = '0;
        last_do[0] = '0;
        last_do[1] = '0;
        repeat (3) cyc();

        chk("rst_busy_a", 32'(a_if.init_busy), 32'd1);
        chk("rst_vld_a",  32'(a_if.r0vld),     32'd0);
        chk("rst_do_a",   32'(a_if.r0do),      32'd0);
        chk("rst_busy_b", 32'(b_if.init_busy), 32'd1);
        chk("rst_vld_b",  32'(b_if.r0vld),     32'd0);

        // Clear sweep on both instances, with gated requests into A while it sweeps.
        rst_a = 1'b0;
        rst_b = 1'b0;
        clear_count(1'b1, na, nb);
        chk("clear_len_a", 32'(na), 32'd256);
        chk("clear_len_b", 32'(nb), 32'd200);
        chk("busy_hold_do", 32'(a_if.r0do), 32'd0);

        for (int i = 0; i < 256; i++) op(0, 1'b0, 0, 9'h0, 2'b00, 1'b1, i, "clr_rd_a");
        chk("busy_gate_mem3", 32'(a_if.r0do), 32'd0);
        op(0, 1'b0, 0, 9'h0, 2'b00, 1'b1, 3, "gate_rd3");
        chk("gate_rd3_const", 32'(a_if.r0do), 32'h000);

        // Masked writes with a partial top lane.
        op(0, 1'b1, 5, 9'h1FF, 2'b11, 1'b0, 0, "t2_w1");
        op(0, 1'b1, 5, 9'h000, 2'b01, 1'b0, 0, "t2_w2");
        op(0, 1'b0, 0, 9'h000, 2'b00, 1'b1, 5, "t2_r1");
        chk("t2_r1_const", 32'(a_if.r0do), 32'h100);
        op(0, 1'b1, 5, 9'h0AA, 2'b10, 1'b0, 0, "t2_w3");
        op(0, 1'b0, 0, 9'h000, 2'b00, 1'b1, 5, "t2_r2");
        chk("t2_r2_const", 32'(a_if.r0do), 32'h000);
        op(0, 1'b1, 6, 9'h1FF, 2'b00, 1'b1, 6, "t2_nomask");

        // Same-address read and write return the old contents.
        op(0, 1'b1, 7, 9'h055, 2'b11, 1'b0, 0, "t3_init");
        op(0, 1'b1, 7, 9'h1AA, 2'b11, 1'b1, 7, "t3_coll");
        chk("t3_coll_const", 32'(a_if.r0do), 32'h055);
        op(0, 1'b0, 0, 9'h000, 2'b00, 1'b1, 7, "t3_after");
        chk("t3_after_const", 32'(a_if.r0do), 32'h1AA);

        // Non-power-of-2 depth: out-of-range writes dropped, reads return zero.
        op(1, 1'b1, 250, 9'h1FF, 2'b11, 1'b0, 0, "t6_w");
        op(1, 1'b0, 0, 9'h000, 2'b00, 1'b1, 250, "t6_r250");
        chk("t6_r250_const", 32'(b_if.r0do), 32'h000);
        op(1, 1'b0, 0, 9'h000, 2'b00, 1'b1, 199, "t6_r199");
        chk("t6_r199_const", 32'(b_if.r0do), 32'h000);

        for (int k = 0; k < 400; k++) begin
            int wa, ra;
            wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            op(0, 1'($urandom_range(0, 1)), wa, 9'($urandom), 2'($urandom), 1'($urandom_range(0, 1)), ra, "rnd_a");
        end
        for (int k = 0; k < 300; k++) begin
            op(1, 1'($urandom_range(0, 1)), int'($urandom_range(180, 255)), 9'($urandom), 2'($urandom),
               1'($urandom_range(0, 1)), int'($urandom_range(180, 255)), "rnd_b");
        end

        // Reset drops an in-flight read and restarts the sweep, also when hit mid-sweep.
        a_if.r0re = 1'b1;
        a_if.r0addr = 8'd7;
        cyc();
        idle();
        chk("t4_inflight_vld", 32'(a_if.r0vld), 32'd1);
        rst_a = 1'b1;
        #1;
        chk("t4_rst_vld", 32'(a_if.r0vld), 32'd0);
        chk("t4_rst_busy", 32'(a_if.init_busy), 32'd1);
        cyc();
        rst_a = 1'b0;
        repeat (100) cyc();
        chk("t4_mid_busy", 32'(a_if.init_busy), 32'd1);
        rst_a = 1'b1;
        repeat (2) cyc();
        chk("t4_rst2_do", 32'(a_if.r0do), 32'd0);
        rst_a = 1'b0;
        clear_count(1'b0, na, nb);
        chk("t4_clear_len", 32'(na), 32'd256);
        for (int i = 0; i < 256; i++) ma[i] = '0;
        last_do[0] = '0;
        for (int i = 0; i < 256; i++) op(0, 1'b0, 0, 9'h0, 2'b00, 1'b1, i, "t4_rd");
        op(0, 1'b0, 0, 9'h0, 2'b00, 1'b1, 7, "t4_rd7");
        chk("t4_rd7_const", 32'(a_if.r0do), 32'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
